// File: rtl/sram_arbiter.sv
// Arbitrates the shared single-port instruction/data SRAM between the fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats fetch.
module sram_arbiter #(
  parameter int SRAM_ADDR_WIDTH   = 11,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_req,
  input  logic [31:0]                i_addr,
  output logic [31:0]                i_rdata,
  output logic                       i_done,
  output logic                       i_err,
  input  logic                       d_req,
  input  logic                       d_wen,
  input  logic [2:0]                 d_funct3,
  input  logic [31:0]                d_addr,
  input  logic [31:0]                d_wdata,
  output logic [31:0]                d_rdata,
  output logic                       d_done,
  output logic                       d_err,
  output logic                       sram_en,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]                sram_wdata,
  input  logic [31:0]                sram_rdata,
  output logic [2:0]                 fsm_state
);
  // Handshake: a port raises req with its inputs stable and holds them until its done pulse;
  // done (with err/rdata) is high for exactly one cycle, and a port is never re-accepted in
  // the cycle its own done is high.
  localparam int BW = SRAM_ADDR_WIDTH + 2;
  localparam int CW = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    RMW_WR   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic            port_d;
  logic [BW-1:0]   a_q;
  logic [2:0]      f3_q;
  logic [15:0]     wdata_q;
  logic [31:0]     old_q;

  logic            i_elig, d_elig, tie_d, sel_d, accept;
  logic [BW-1:0]   a_addr;
  logic [2:0]      a_f3;
  logic            a_wen, misalign, illegal, a_err;
  logic            rd_capture, rmw_capture;
  logic            enter_done, done_d, done_err;
  logic [4:0]      sh_b, sh_h;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_ext, merged;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^{i_addr[31:BW], d_addr[31:BW]};
  assign fsm_state = state;

`ifdef MEM_ARB_RR_EN
  logic rr_last_d;  // 1 when the data port held the most recent grant
  assign tie_d = !rr_last_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rr_last_d <= 1'b0;
    else if (accept) rr_last_d <= sel_d;
  end
`else
  assign tie_d = 1'b1;
`endif

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    sh_b   = {a_q[1:0], 3'b000};
    sh_h   = {a_q[1], 4'b0000};
    byte_v = 8'(sram_rdata >> sh_b);
    half_v = 16'(sram_rdata >> sh_h);
    case (f3_q)
      3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_ext = {{16{half_v[15]}}, half_v};
      3'b100:  load_ext = {24'h0, byte_v};
      3'b101:  load_ext = {16'h0, half_v};
      default: load_ext = sram_rdata;
    endcase
    if (f3_q[0])
      merged = (sram_rdata & ~(32'h0000_FFFF << sh_h)) | (32'(wdata_q) << sh_h);
    else
      merged = (sram_rdata & ~(32'h0000_00FF << sh_b)) | (32'(wdata_q[7:0]) << sh_b);
  end

  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    rd_capture  = 1'b0;
    rmw_capture = 1'b0;

    i_elig = i_req && !i_done;
    d_elig = d_req && !d_done;
    sel_d  = d_elig && (!i_elig || tie_d);
    a_addr = sel_d ? d_addr[BW-1:0] : i_addr[BW-1:0];
    a_f3   = sel_d ? d_funct3 : 3'b010;
    a_wen  = sel_d && d_wen;

    misalign = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
               ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    illegal  = a_wen ? (a_f3 >= 3'b011)
                     : ((a_f3 == 3'b011) || (a_f3 == 3'b110) || (a_f3 == 3'b111));
    a_err    = misalign || illegal;
    accept   = n_rst && ((state == IDLE) || (state == DONE)) && (i_elig || d_elig);

    case (state)
      IDLE, DONE: begin
        if (state == DONE) next_state = IDLE;
        if (accept) begin
          if (a_err) begin
            next_state = DONE;
          end else if (!a_wen) begin
            sram_en    = 1'b1;
            sram_addr  = a_addr[BW-1:2];
            next_state = RD_WAIT;
          end else if (a_f3 == 3'b010) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = a_addr[BW-1:2];
            sram_wdata = d_wdata;
            next_state = DONE;
          end else begin
            sram_en    = 1'b1;
            sram_addr  = a_addr[BW-1:2];
            next_state = RMW_WAIT;
          end
        end
      end
      RD_WAIT, RMW_WAIT: begin
        if (cnt == CNT_LAST) begin
          next_cnt    = '0;
          rd_capture  = (state == RD_WAIT);
          rmw_capture = (state == RMW_WAIT);
          next_state  = (state == RD_WAIT) ? DONE : RMW_WR;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      RMW_WR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = a_q[BW-1:2];
        sram_wdata = old_q;
        next_state = DONE;
      end
      default: next_state = IDLE;
    endcase

    enter_done = (next_state == DONE);
    done_d     = accept ? sel_d : port_d;
    done_err   = accept && a_err;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      port_d  <= 1'b0;
      a_q     <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        port_d  <= sel_d;
        a_q     <= a_addr;
        f3_q    <= a_f3;
        wdata_q <= d_wdata[15:0];
      end
      if (rd_capture) begin
        if (port_d) d_rdata <= load_ext;
        else        i_rdata <= load_ext;
      end
      if (rmw_capture) old_q <= merged;
      // Rejected accesses report a zero result
      if (accept && a_err) begin
        if (sel_d) d_rdata <= '0;
        else       i_rdata <= '0;
      end
      i_done <= enter_done && !done_d;
      d_done <= enter_done && done_d;
      i_err  <= enter_done && !done_d && done_err;
      d_err  <= enter_done && done_d && done_err;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model with 2-cycle read latency, byte-level reference memory,
// directed cases followed by randomized single accesses and contention scenarios.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, i_err, d_done, d_err;
  logic        sram_en, sram_we;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  rb [0:8191];
  logic        last_d;

  sram_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .fsm_state(dbg_state)
  );

  // Clock and SRAM model
  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic [31:0] rd_p1 = 32'hDEAD_BEEF;
  logic [31:0] rd_p2 = 32'hDEAD_BEEF;
  int          cyc   = 0;
  int          n_en  = 0;
  int          n_we  = 0;
  int          we_cyc = -1;
  logic [31:0] we_data = '0;
  logic [10:0] we_addr = '0;

  assign sram_rdata = rd_p2;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_p2 <= rd_p1;
    rd_p1 <= (sram_en && !sram_we) ? mem[sram_addr] : 32'hDEAD_BEEF;
    if (sram_en) n_en <= n_en + 1;
    if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_wdata;
      n_we    <= n_we + 1;
      we_cyc  <= cyc;
      we_data <= sram_wdata;
      we_addr <= sram_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory, only the low 13 address bits reach the SRAM
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[12:2], 2'b00});
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input bit fetch, input logic wen, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit bad;
    if (fetch) return (a % 4) != 0;
    if (wen) bad = (f3 >= 3'd3);
    else     bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return bad || ((a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int b, v;
    b = int'(a[12:0]);
    case (f3)
      3'd0: begin v = rb[b]; if (v >= 128) v -= 256; end
      3'd1: begin v = rb[b] + 256 * rb[b+1]; if (v >= 32768) v -= 65536; end
      3'd4: v = rb[b];
      3'd5: v = rb[b] + 256 * rb[b+1];
      default: v = int'(ref_word(a));
    endcase
    return 32'(v);
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd);
    int b;
    b = int'(a[12:0]);
    for (int i = 0; i < acc_size(f3); i++) rb[b+i] = wd[8*i +: 8];
  endfunction

  // Driver: issue one request, wait for its done pulse, scramble the held inputs after accept
  task automatic run_op(input bit fetch, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int t0);
    if (fetch) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_wen = wen; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end
    t0 = cyc; lat = -1; rdata = '0; err = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (fetch ? i_done : d_done) begin
        lat   = cyc - t0;
        rdata = fetch ? i_rdata : d_rdata;
        err   = fetch ? i_err : d_err;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        i_addr = $urandom(); d_addr = $urandom(); d_wdata = $urandom();
        d_funct3 = 3'($urandom()); d_wen = 1'($urandom());
      end
      if (lat >= 0) break;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit fetch, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int t0);
    bit e; int el, en0, lat; logic err;
    e  = ref_err(fetch, wen, f3, addr);
    el = e ? 1 : (fetch || !wen) ? 3 : (f3 == 3'd2) ? 1 : 4;
    exp_q.push_back(e ? 32'h0 : fetch ? ref_word(addr) : (!wen ? ref_load(f3, addr) : 32'h0));
    en0 = n_en;
    run_op(fetch, wen, f3, addr, wdata, rdata, err, lat, t0);
    check({tag, "_lat"}, lat, el);
    check({tag, "_err"}, 32'(err), 32'(e));
    if (e || fetch || !wen) check({tag, "_rdata"}, rdata, exp_q.pop_front());
    else void'(exp_q.pop_front());
    if (e) check({tag, "_no_sram"}, n_en - en0, 0);
    if (!e && !fetch && wen) ref_store(f3, addr, wdata);
    last_d = !fetch;
  endtask

  // Both ports request LW/fetch; hold both for 'hold' cycles, then drop each after its done
  task automatic contend(input string tag, input int hold);
    logic [31:0] got_q[$];
    bit draining, drop_i, drop_d;
    logic w;
    i_addr = 32'h20; d_wen = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10; d_wdata = '0;
    i_req = 1'b1; d_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    w = !last_d;
`else
    w = 1'b1;
`endif
    for (int k = 0; k < hold + 40; k++) begin
      draining = (k >= hold);
      @(negedge clk);
      drop_i = 1'b0; drop_d = 1'b0;
      if (d_done) begin
        got_q.push_back(32'd1);
        check({tag, "_d_rdata"}, d_rdata, ref_word(32'h10));
        drop_d = draining;
      end
      if (i_done) begin
        got_q.push_back(32'd0);
        check({tag, "_i_rdata"}, i_rdata, ref_word(32'h20));
        drop_i = draining;
      end
      @(posedge clk); #1;
      if (drop_d) d_req = 1'b0;
      if (drop_i) i_req = 1'b0;
      if (!i_req && !d_req) break;
    end
    check({tag, "_drained"}, 32'({i_req, d_req}), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    check({tag, "_count_ok"}, 32'(got_q.size() >= ((hold > 0) ? 10 : 2)), 32'd1);
    foreach (got_q[i]) begin
      exp_q.push_back(32'(w));
      w = !w;
    end
    foreach (got_q[i]) check({tag, "_order"}, got_q[i], exp_q.pop_front());
    if (got_q.size() > 0) last_d = got_q[got_q.size()-1][0];
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [2:0]  f3;
    logic        w;
    bit          f;
    int          t0, we0, seen;

    n_rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; d_funct3 = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; last_d = 1'b0;
    for (int i = 0; i < 8192; i++) rb[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_i_done", 32'(i_done), 0);
    check("rst_d_done", 32'(d_done), 0);
    check("rst_i_err", 32'(i_err), 0);
    check("rst_d_err", 32'(d_err), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_sram_en", 32'(sram_en), 0);
    check("rst_sram_we", 32'(sram_we), 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // Preload the 16-word working region through the store path
    for (int i = 0; i < 16; i++) do_op("pre_sw", 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom(), rd, t0);

    // Extension cases over word 4 = 0x8899AABB
    do_op("sw_w4", 1'b0, 1'b1, 3'b010, 32'h10, 32'h8899AABB, rd, t0);
    do_op("lb", 1'b0, 1'b0, 3'b000, 32'h12, 32'h0, rd, t0);
    check("lb_value", rd, 32'hFFFFFF99);
    do_op("lbu", 1'b0, 1'b0, 3'b100, 32'h12, 32'h0, rd, t0);
    check("lbu_value", rd, 32'h00000099);
    do_op("lh", 1'b0, 1'b0, 3'b001, 32'h12, 32'h0, rd, t0);
    check("lh_value", rd, 32'hFFFF8899);
    do_op("lhu_lo", 1'b0, 1'b0, 3'b101, 32'h10, 32'h0, rd, t0);
    check("lhu_value", rd, 32'h0000AABB);

    // Byte store as read-modify-write
    do_op("sw_w4b", 1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, t0);
    we0 = n_we;
    do_op("sb", 1'b0, 1'b1, 3'b000, 32'h11, 32'h55, rd, t0);
    check("sb_one_write", n_we - we0, 1);
    check("sb_write_cycle", we_cyc - t0, 3);
    check("sb_write_data", we_data, 32'h11225544);
    check("sb_write_addr", 32'(we_addr), 32'd4);
    do_op("lw_after_sb", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, t0);
    check("lw_after_sb_value", rd, 32'h11225544);
    do_op("sh_hi", 1'b0, 1'b1, 3'b001, 32'h1E, 32'hCAFEBEEF, rd, t0);
    do_op("lw_after_sh", 1'b0, 1'b0, 3'b010, 32'h1C, 32'h0, rd, t0);

    // Rejected accesses
    do_op("lw_misalign", 1'b0, 1'b0, 3'b010, 32'h6, 32'h0, rd, t0);
    do_op("fetch_misalign", 1'b1, 1'b0, 3'b010, 32'h2, 32'h0, rd, t0);
    do_op("load_f3_011", 1'b0, 1'b0, 3'b011, 32'h10, 32'h0, rd, t0);
    do_op("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h13, 32'h1234, rd, t0);
    do_op("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h10, 32'h1234, rd, t0);
    do_op("fetch_ok", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, t0);
    do_op("lw_wrap", 1'b0, 1'b0, 3'b010, 32'hFFFF_E010, 32'h0, rd, t0);

    // Contention: long hold, then a single tie after a data-only grant
    contend("hold", 30);
    do_op("lw_solo", 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, t0);
    contend("tie", 0);

    // Reset in the middle of an SH read-modify-write
    we0 = n_we;
    d_req = 1'b1; d_wen = 1'b1; d_funct3 = 3'b001; d_addr = 32'h22; d_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    #1 n_rst = 1'b0;
    d_req = 1'b0;
    #1;
    check("mid_rst_i_done", 32'(i_done), 0);
    check("mid_rst_d_done", 32'(d_done), 0);
    check("mid_rst_i_err", 32'(i_err), 0);
    check("mid_rst_d_err", 32'(d_err), 0);
    check("mid_rst_i_rdata", i_rdata, 0);
    check("mid_rst_d_rdata", d_rdata, 0);
    check("mid_rst_sram_en", 32'(sram_en), 0);
    check("mid_rst_sram_we", 32'(sram_we), 0);
    check("mid_rst_sram_addr", 32'(sram_addr), 0);
    check("mid_rst_sram_wdata", sram_wdata, 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_done || i_done) seen++;
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_write", n_we - we0, 0);
    check("mid_rst_no_done", seen, 0);
    last_d = 1'b0;
    do_op("lw_after_rst", 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, t0);
    last_d = 1'b0;
    n_rst = 1'b0;
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    contend("tie_after_rst", 0);

    // Randomized single accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      f  = ($urandom_range(0, 4) == 0);
      w  = 1'($urandom());
      f3 = 3'($urandom());
      a  = ($urandom() & 32'hFFFF_E000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom();
      do_op("rand", f, w, f3, a, wd, rd, t0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
